// File: rtl/signed_product_accumulator.sv
// Signed accumulator of 8-bit multiplier products over a run of len terms, with sticky overflow.
// Optional build macro ACC_SATURATE_EN clamps acc on overflow; without it acc wraps modulo 2^ACC_W.
module signed_product_accumulator #(
    parameter int ACC_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       prod,
    input  logic             prod_ovf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc,
    output logic             ovf,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [3:0]       cnt_q, cnt_d;

    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] sum;
    logic [ACC_W-1:0] add_result;
    logic             add_ovf;
    logic             transfer;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    // Signed overflow: operands share a sign and the sum's sign differs from it.
    always_comb begin
        prod_ext = {{(ACC_W-8){prod[7]}}, prod};
        sum      = acc_q + prod_ext;
        add_ovf  = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) &&
                   (sum[ACC_W-1] != acc_q[ACC_W-1]);
`ifdef ACC_SATURATE_EN
        if (add_ovf) begin
            add_result = acc_q[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                        : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            add_result = sum;
        end
`else
        add_result = sum;
`endif
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        ovf_d     = ovf_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        transfer  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = len;
                    state_d = (len == 4'd0) ? DONE : ACC;
                end
            end
            ACC: begin
                in_ready = 1'b1;
                transfer = in_valid;
                if (transfer) begin
                    acc_d = add_result;
                    ovf_d = ovf_q | prod_ovf | add_ovf;
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign acc  = acc_q;
    assign ovf  = ovf_q;
    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_signed_product_accumulator.sv
// Scoreboard bench for signed_product_accumulator: directed runs push expected {ovf,acc};
// a negedge monitor pops and compares on every output handshake.
module tb_signed_product_accumulator;

    localparam int ACC_W = 10;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [3:0]       len;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       prod;
    logic             prod_ovf;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] acc;
    logic             ovf;
    logic             busy;

    int checks = 0;
    int fails  = 0;

    logic [ACC_W:0] exp_q[$];

    signed_product_accumulator #(.ACC_W(ACC_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .prod      (prod),
        .prod_ovf  (prod_ovf),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc       (acc),
        .ovf       (ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [15:0] actual,
                                input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Monitor: every accepted result must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("[TB] FAIL unexpected_result: got acc=0x%0h ovf=%0b, expected none", acc, ovf);
            end else begin
                logic [ACC_W:0] e;
                e = exp_q.pop_front();
                check_output("result_acc", 16'(acc), 16'(e[ACC_W-1:0]));
                check_output("result_ovf", 16'(ovf), 16'(e[ACC_W]));
            end
        end
    end

    task automatic start_run(input logic [3:0] n);
        start = 1'b1;
        len   = n;
        @(posedge clk); #1;
        start = 1'b0;
        len   = 4'd0;
    endtask

    task automatic send_term(input logic [7:0] p, input logic po);
        check_output("in_ready_acc", 16'(in_ready), 16'd1);
        in_valid = 1'b1;
        prod     = p;
        prod_ovf = po;
        @(posedge clk); #1;
        in_valid = 1'b0;
        prod     = 8'h00;
        prod_ovf = 1'b0;
    endtask

    // Waits (bounded) for out_valid, holds out_ready low for hold cycles checking stability, then accepts.
    task automatic collect(input int hold);
        int waited;
        logic [ACC_W-1:0] held_acc;
        logic             held_ovf;
        waited = 0;
        while (!out_valid && waited < 8) begin
            @(posedge clk); #1;
            waited++;
        end
        check_output("out_valid_seen", 16'(out_valid), 16'd1);
        held_acc = acc;
        held_ovf = ovf;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check_output("hold_valid", 16'(out_valid), 16'd1);
            check_output("hold_acc", 16'(acc), 16'(held_acc));
            check_output("hold_ovf", 16'(ovf), 16'(held_ovf));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_output("idle_after_accept", 16'(busy), 16'd0);
    endtask

    task automatic apply_stimulus();
        // Reset state
        rst_n = 1'b0; start = 1'b0; len = 4'd0; in_valid = 1'b0;
        prod = 8'h00; prod_ovf = 1'b0; out_ready = 1'b0;
        #12;
        check_output("rst_acc", 16'(acc), 16'h0);
        check_output("rst_ovf", 16'(ovf), 16'h0);
        check_output("rst_in_ready", 16'(in_ready), 16'h0);
        check_output("rst_out_valid", 16'(out_valid), 16'h0);
        check_output("rst_busy", 16'(busy), 16'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // 5 + (-2) + 7 = 10, result one cycle after last transfer
        exp_q.push_back({1'b0, 10'h00A});
        start_run(4'd3);
        check_output("busy_acc", 16'(busy), 16'd1);
        send_term(8'h05, 1'b0);
        send_term(8'hFE, 1'b0);
        send_term(8'h07, 1'b0);
        check_output("latency_out_valid", 16'(out_valid), 16'd1);
        collect(0);

        // len=0 goes straight to DONE; start during the accepting cycle is ignored
        exp_q.push_back({1'b0, 10'h000});
        start_run(4'd0);
        check_output("len0_out_valid", 16'(out_valid), 16'd1);
        check_output("len0_in_ready", 16'(in_ready), 16'd0);
        start = 1'b1; len = 4'd2; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; len = 4'd0; out_ready = 1'b0;
        check_output("start_ignored_in_done", 16'(busy), 16'd0);

        // Multiplier overflow flag is sticky
        exp_q.push_back({1'b1, 10'h011});
        start_run(4'd2);
        send_term(8'h10, 1'b1);
        send_term(8'h01, 1'b0);
        collect(0);
        check_output("idle_hold_acc", 16'(acc), 16'h011);
        check_output("idle_hold_ovf", 16'(ovf), 16'h1);

        // 127 x5 overflows the 10-bit accumulator
`ifdef ACC_SATURATE_EN
        exp_q.push_back({1'b1, 10'h1FF});
`else
        exp_q.push_back({1'b1, 10'h27B});
`endif
        start_run(4'd5);
        for (int i = 0; i < 5; i++) send_term(8'h7F, 1'b0);
        collect(0);

        // Gap of 3 idle input cycles and 4 cycles of backpressure
        exp_q.push_back({1'b0, 10'h006});
        start_run(4'd3);
        send_term(8'h01, 1'b0);
        prod = 8'h55; prod_ovf = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        check_output("gap_acc", 16'(acc), 16'h001);
        check_output("gap_ovf", 16'(ovf), 16'h0);
        send_term(8'h02, 1'b0);
        send_term(8'h03, 1'b0);
        collect(4);

        // Reset mid-run abandons the run
        start_run(4'd4);
        send_term(8'h20, 1'b0);
        send_term(8'h30, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_output("midrst_acc", 16'(acc), 16'h0);
        check_output("midrst_ovf", 16'(ovf), 16'h0);
        check_output("midrst_in_ready", 16'(in_ready), 16'h0);
        check_output("midrst_busy", 16'(busy), 16'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_output("postrst_out_valid", 16'(out_valid), 16'h0);
        exp_q.push_back({1'b0, 10'h3FF});
        start_run(4'd1);
        send_term(8'hFF, 1'b0);
        collect(0);

        repeat (3) @(posedge clk);
        check_output("scoreboard_empty", 16'(exp_q.size()), 16'd0);
    endtask

    initial begin
        apply_stimulus();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/signed_product_accumulator.md
SIGNED_PRODUCT_ACCUMULATOR -- requirements
Module: signed_product_accumulator

Interface
REQ-001 Parameter ACC_W, default 10, SHALL set the signed accumulator width; legal range 9..16.
REQ-002 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 start  input  1  SHALL request a new accumulation run; sampled only in IDLE.
REQ-005 len  input  4  SHALL give the number of product terms in the run (0..15); sampled with start.
REQ-006 in_valid  input  1  SHALL mark prod/prod_ovf as valid.
REQ-007 in_ready  output  1  SHALL indicate the block accepts a term this cycle.
REQ-008 prod  input  8  SHALL carry the signed two's-complement product from the 8x8 signed multiplier.
REQ-009 prod_ovf  input  1  SHALL carry the multiplier's overflow flag for prod.
REQ-010 out_valid  output  1  SHALL indicate acc/ovf hold a completed result.
REQ-011 out_ready  input  1  SHALL indicate the consumer takes the result.
REQ-012 acc  output  ACC_W  SHALL present the signed accumulated sum.
REQ-013 ovf  output  1  SHALL present the sticky overflow for the run.
REQ-014 busy  output  1  SHALL be 1 whenever the state is not IDLE.

Function
REQ-015 The FSM SHALL have three states: IDLE, ACC, DONE.
REQ-016 IDLE: in_ready=0, out_valid=0; on start=1, clear acc and ovf to 0 and load the remaining-term counter with len; go to DONE if len=0, else to ACC.
REQ-017 start SHALL be ignored in ACC and DONE, including in the same cycle as the DONE handshake.
REQ-018 ACC: in_ready=1; a transfer occurs only when in_valid=1 and in_ready=1; cycles with in_valid=0 SHALL leave acc, ovf and the counter unchanged.
REQ-019 On each transfer, acc SHALL become acc + sign-extend(prod) (ACC_W-bit), ovf SHALL OR in prod_ovf and the addition overflow, and the counter SHALL decrement.
REQ-020 Addition overflow SHALL be flagged when acc and sign-extend(prod) have equal sign bits and the sum's sign bit differs.
REQ-021 The transfer that takes the counter from 1 to 0 SHALL move the state to DONE; out_valid SHALL rise on the next cycle with the final acc (latency 1 cycle after the last transfer).
REQ-022 DONE: in_ready=0, out_valid=1, acc and ovf stable; on out_ready=1 go to IDLE.
REQ-023 acc and ovf SHALL hold their last values in IDLE until the next accepted start.

Reset
REQ-024 rst_n=0 SHALL, without waiting for clk, force state=IDLE, acc=0, ovf=0, counter=0, in_ready=0, out_valid=0, busy=0.
REQ-025 Reset asserted mid-run (ACC or DONE) SHALL abandon the run; no partial result SHALL be presented after release.
REQ-026 After release, the first rising edge SHALL already sample start.

Configuration
REQ-027 With macro ACC_SATURATE_EN defined, an overflowing addition SHALL clamp acc to the maximum positive value (2^(ACC_W-1)-1) on positive overflow or the minimum negative value (-2^(ACC_W-1)) on negative overflow; later terms add to the clamped value.
REQ-028 Without ACC_SATURATE_EN, acc SHALL wrap modulo 2^ACC_W; ovf behaviour SHALL be identical in both builds.

Verification
REQ-029 ACC_W=10, len=3, prod=5,-2,7 back-to-back -> acc=0x00A, ovf=0, out_valid high 1 cycle after the third transfer.
REQ-030 start with len=0 -> DONE next cycle, acc=0x000, ovf=0, no in_ready pulse.
REQ-031 len=2, prod=0x10 with prod_ovf=1, then 0x01 -> acc=0x011, ovf=1.
REQ-032 ACC_W=10, len=5, prod=0x7F (127) x5 -> ovf=1; acc=0x1FF with ACC_SATURATE_EN, acc=0x27B without.
REQ-033 in_valid low for 3 cycles mid-run and out_ready low for 4 cycles in DONE -> no extra accumulation, out_valid and acc held stable until out_ready=1, then IDLE.
REQ-034 rst_n pulsed low during ACC after 2 of 4 terms -> acc=0, ovf=0, in_ready=0, busy=0 immediately; a following len=1, prod=-1 run gives acc=0x3FF.
